load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter SIZE, default 1024: byte capacity of the downstream memory, used for range checking.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, low-aligned.
REQ-010 SHALL have port resp_valid  output  1  response present.
REQ-011 SHALL have port resp_ready  input  1  consumer accepts the response.
REQ-012 SHALL have port resp_data  output  32  formatted load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  request rejected; no memory write performed.
REQ-014 SHALL have ports mem_rd_addr (output, 32), mem_rd_data (input, 32), mem_wr (output, 2; 0 none, 1 byte, 2 half, 3 word), mem_wr_addr (output, 32) and mem_wr_data (output, 32), which connect to a memory with a 1-cycle registered read.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, CAPTURE and RESP; req_ready SHALL be 1 only in IDLE, and requests SHALL NOT overlap.
REQ-016 SHALL accept a request on the edge where req_valid && req_ready are both high, latch all req_* fields, and go to ISSUE.
REQ-017 In ISSUE, SHALL drive registered mem_rd_addr = mem_wr_addr = latched addr and mem_wr_data = latched wdata, unmodified.
REQ-018 In ISSUE, mem_wr SHALL be 1/2/3 for a valid store of B/H/W and 0 otherwise; mem_wr SHALL be 0 in every other state.
REQ-019 From ISSUE, a load SHALL go to CAPTURE, and a store or error SHALL go to RESP.
REQ-020 In CAPTURE, SHALL format mem_rd_data into resp_data and go to RESP: B sign-extends [7:0], BU zero-extends [7:0], H sign-extends [15:0], HU zero-extends [15:0], W passes through.
REQ-021 In RESP, resp_valid SHALL be 1 with resp_data and resp_err held stable until resp_valid && resp_ready, after which the FSM SHALL go to IDLE.
REQ-022 Latency from the acceptance edge to resp_valid high SHALL be 3 edges for a load and 2 edges for a store or error; with resp_ready held high, throughput SHALL be one request per 4 cycles (load) or 3 cycles (store/error).
REQ-023 SHALL set resp_err for an illegal code: funct3 of 011, 110 or 111, or a store with funct3[2] = 1.
REQ-024 SHALL set resp_err for an out-of-range access, where addr + nbytes > SIZE is computed in 33 bits (nbytes = 1/2/4), so address wrap-around is never silently accepted.
REQ-025 An errored request SHALL perform no memory write and SHALL return resp_data = 0.
REQ-026 resp_data SHALL be 0 for every store.

Reset
REQ-027 While rst_n is low at an edge, SHALL set state to IDLE and clear resp_valid, resp_err, resp_data, mem_rd_addr, mem_wr_addr and mem_wr_data to 0.
REQ-028 mem_wr SHALL be combinationally forced to 0 whenever rst_n is low, so that a store caught in ISSUE is never committed.
REQ-029 req_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.
REQ-030 Reset mid-operation SHALL discard the in-flight request with no response.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN, when defined: H/HU/SH with addr[0] = 1, and W/SW with addr[1:0] != 0, SHALL set resp_err with no memory write.
REQ-032 Macro LSU_MISALIGN_TRAP_EN, when undefined: misaligned accesses SHALL be performed as byte-contiguous accesses starting at addr, with no error.

Verification
REQ-033 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_wr = 3 for one cycle; load returns 0xDEADBEEF 3 edges after acceptance, resp_err = 0.
REQ-034 Memory at 0x20 = 0x80; LB 0x20 -> 0xFFFFFF80; LBU 0x20 -> 0x00000080; LH 0x20 (byte 0x21 = 0x00) -> 0x00000080.
REQ-035 SH addr 0x3FF (SIZE 1024) -> resp_err = 1, mem_wr stays 0, resp_data = 0; SB 0x3FF -> accepted, mem_wr = 1.
REQ-036 LW 0x102: with LSU_MISALIGN_TRAP_EN -> resp_err = 1 after 2 edges; without it -> bytes 0x102..0x105, resp_err = 0.
REQ-037 Hold resp_ready = 0 for 5 cycles in RESP -> resp_valid, resp_data and resp_err stable; req_ready = 0 throughout; IDLE on the cycle after resp_ready rises.
REQ-038 Assert rst_n = 0 during ISSUE of SW 0x40 0x12345678 -> mem_wr = 0, memory at 0x40 unchanged, no response, req_ready = 1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one request in flight, RV32I width formatting, range/illegal-code checks.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors.
module load_store_unit #(
  parameter int unsigned SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  output logic [1:0]  mem_wr,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_f3;
  logic        r_err;
  logic [1:0]  r_mem_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_data;

  logic [2:0]  w_nbytes;
  logic [32:0] w_end;
  logic        w_oor;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_err;
  logic [1:0]  w_wr_code;
  logic [31:0] w_fmt;

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   w_nbytes = 3'd1;
      2'b01:   w_nbytes = 3'd2;
      default: w_nbytes = 3'd4;
    endcase
  end

  // 33-bit sum so an address near 2^32 cannot wrap back into range
  assign w_end     = {1'b0, req_addr} + {30'd0, w_nbytes};
  assign w_oor     = w_end > 33'(SIZE);
  assign w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                     (req_we && req_funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = w_illegal || w_oor || w_misalign;

  always_comb begin
    w_wr_code = 2'd0;
    if (req_we && !w_err) begin
      case (req_funct3[1:0])
        2'b00:   w_wr_code = 2'd1;
        2'b01:   w_wr_code = 2'd2;
        default: w_wr_code = 2'd3;
      endcase
    end
  end

  always_comb begin
    case (r_f3)
      3'b000:  w_fmt = {{24{mem_rd_data[7]}}, mem_rd_data[7:0]};
      3'b100:  w_fmt = {24'd0, mem_rd_data[7:0]};
      3'b001:  w_fmt = {{16{mem_rd_data[15]}}, mem_rd_data[15:0]};
      3'b101:  w_fmt = {16'd0, mem_rd_data[15:0]};
      default: w_fmt = mem_rd_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_f3         <= 3'd0;
      r_err        <= 1'b0;
      r_mem_wr     <= 2'd0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_we     <= req_we;
          r_f3     <= req_funct3;
          r_err    <= w_err;
          r_addr   <= req_addr;
          r_wdata  <= req_wdata;
          r_mem_wr <= w_wr_code;
          r_state  <= ISSUE;
        end
        ISSUE: begin
          r_mem_wr <= 2'd0;
          if (!r_we && !r_err) begin
            r_state <= CAPTURE;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= r_err;
            r_resp_data  <= 32'd0;
            r_state      <= RESP;
          end
        end
        CAPTURE: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_data  <= w_fmt;
          r_state      <= RESP;
        end
        RESP: if (resp_ready) begin
          r_resp_valid <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready   = rst_n && (r_state == IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_err    = r_resp_err;
  assign resp_data   = r_resp_data;
  assign mem_rd_addr = r_addr;
  assign mem_wr_addr = r_addr;
  assign mem_wr_data = r_wdata;
  // a store caught in ISSUE by reset must never reach memory
  assign mem_wr      = rst_n ? r_mem_wr : 2'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed 1-cycle-read memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_data, mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;
  logic [1:0]  mem_wr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.SIZE(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_wr(mem_wr),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  logic [7:0]  m [0:2047];
  logic [10:0] ra, wa;
  assign ra = mem_rd_addr[10:0];
  assign wa = mem_wr_addr[10:0];

  always @(posedge clk) begin
    mem_rd_data <= {m[ra + 11'd3], m[ra + 11'd2], m[ra + 11'd1], m[ra]};
    if (mem_wr != 2'd0) m[wa] <= mem_wr_data[7:0];
    if (mem_wr >= 2'd2) m[wa + 11'd1] <= mem_wr_data[15:8];
    if (mem_wr == 2'd3) begin
      m[wa + 11'd2] <= mem_wr_data[23:16];
      m[wa + 11'd3] <= mem_wr_data[31:24];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // issue one request with resp_ready high; returns response, latency in edges and write info
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] d, output logic e, output int lat,
                      output logic [1:0] wc, output int wcnt);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; wc = mem_wr; wcnt = (mem_wr != 2'd0) ? 1 : 0;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (mem_wr != 2'd0) wcnt++;
    end
    d = resp_data; e = resp_err;
    @(posedge clk); #1;
  endtask

  logic [31:0] d;
  logic        e;
  int          lat, wcnt;
  logic [1:0]  wc;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_mem_wr", {30'd0, mem_wr}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

    // SW then LW
    xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, e, lat, wc, wcnt);
    chk("sw_wcode", {30'd0, wc}, 32'd3);
    chk("sw_wcnt", 32'(wcnt), 32'd1);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_data", d, 32'd0);
    chk("sw_err", {31'd0, e}, 32'd0);
    xact(1'b0, 3'b010, 32'h10, 32'd0, d, e, lat, wc, wcnt);
    chk("lw_data", d, 32'hDEADBEEF);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_err", {31'd0, e}, 32'd0);
    chk("lw_wcnt", 32'(wcnt), 32'd0);

    // byte/half formatting
    xact(1'b1, 3'b000, 32'h20, 32'hAAAAAA80, d, e, lat, wc, wcnt);
    chk("sb_wcode", {30'd0, wc}, 32'd1);
    xact(1'b1, 3'b000, 32'h21, 32'h00, d, e, lat, wc, wcnt);
    xact(1'b0, 3'b000, 32'h20, 32'd0, d, e, lat, wc, wcnt);
    chk("lb", d, 32'hFFFFFF80);
    xact(1'b0, 3'b100, 32'h20, 32'd0, d, e, lat, wc, wcnt);
    chk("lbu", d, 32'h00000080);
    xact(1'b0, 3'b001, 32'h20, 32'd0, d, e, lat, wc, wcnt);
    chk("lh", d, 32'h00000080);
    xact(1'b1, 3'b001, 32'h30, 32'h1234F00D, d, e, lat, wc, wcnt);
    chk("sh_wcode", {30'd0, wc}, 32'd2);
    xact(1'b0, 3'b001, 32'h30, 32'd0, d, e, lat, wc, wcnt);
    chk("lh_neg", d, 32'hFFFFF00D);
    xact(1'b0, 3'b101, 32'h30, 32'd0, d, e, lat, wc, wcnt);
    chk("lhu", d, 32'h0000F00D);

    // range boundaries
    xact(1'b1, 3'b001, 32'h3FF, 32'h5555, d, e, lat, wc, wcnt);
    chk("sh_oor_err", {31'd0, e}, 32'd1);
    chk("sh_oor_wcnt", 32'(wcnt), 32'd0);
    chk("sh_oor_data", d, 32'd0);
    chk("sh_oor_lat", 32'(lat), 32'd2);
    xact(1'b1, 3'b000, 32'h3FF, 32'h5A, d, e, lat, wc, wcnt);
    chk("sb_edge_err", {31'd0, e}, 32'd0);
    chk("sb_edge_wcode", {30'd0, wc}, 32'd1);
    xact(1'b0, 3'b100, 32'h3FF, 32'd0, d, e, lat, wc, wcnt);
    chk("lbu_edge", d, 32'h0000005A);
    xact(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, d, e, lat, wc, wcnt);
    chk("lw_wrap_err", {31'd0, e}, 32'd1);
    chk("lw_wrap_lat", 32'(lat), 32'd2);

    // illegal codes
    xact(1'b0, 3'b011, 32'h10, 32'd0, d, e, lat, wc, wcnt);
    chk("ld011_err", {31'd0, e}, 32'd1);
    chk("ld011_data", d, 32'd0);
    xact(1'b1, 3'b100, 32'h10, 32'hFF, d, e, lat, wc, wcnt);
    chk("st100_err", {31'd0, e}, 32'd1);
    chk("st100_wcnt", 32'(wcnt), 32'd0);
    xact(1'b0, 3'b111, 32'h10, 32'd0, d, e, lat, wc, wcnt);
    chk("ld111_err", {31'd0, e}, 32'd1);

    // misaligned word
    xact(1'b1, 3'b010, 32'h100, 32'h33221100, d, e, lat, wc, wcnt);
    xact(1'b1, 3'b010, 32'h104, 32'h77665544, d, e, lat, wc, wcnt);
    xact(1'b0, 3'b010, 32'h102, 32'd0, d, e, lat, wc, wcnt);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_err", {31'd0, e}, 32'd1);
    chk("lw_mis_lat", 32'(lat), 32'd2);
    chk("lw_mis_data", d, 32'd0);
`else
    chk("lw_mis_err", {31'd0, e}, 32'd0);
    chk("lw_mis_lat", 32'(lat), 32'd3);
    chk("lw_mis_data", d, 32'h55443322);
`endif

    // back-pressure on the response
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; resp_ready = 1'b0;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("stall_valid0", {31'd0, resp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, resp_valid}, 32'd1);
      chk("stall_data", resp_data, 32'hDEADBEEF);
      chk("stall_err", {31'd0, resp_err}, 32'd0);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_idle", {31'd0, req_ready}, 32'd1);
    chk("stall_drop", {31'd0, resp_valid}, 32'd0);

    // reset during ISSUE of a store
    xact(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, d, e, lat, wc, wcnt);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h12345678;
    @(posedge clk); #1; req_valid = 1'b0;
    rst_n = 1'b0;
    #1 chk("rst_issue_wr", {30'd0, mem_wr}, 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_mid_rel", {31'd0, req_ready}, 32'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        if (resp_valid) seen++;
      end
      chk("rst_no_resp", 32'(seen), 32'd0);
    end
    xact(1'b0, 3'b010, 32'h40, 32'd0, d, e, lat, wc, wcnt);
    chk("rst_mem_kept", d, 32'hCAFEF00D);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
